// File: rtl/axil_master_pkg.sv
// Shared types for the AXI4-Lite command master: FSM states and AXI response codes.
package axil_master_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axil_cmd_master.sv
// AXI4-Lite initiator with one transaction in flight: a command/response handshake
// becomes a single-beat AXI write or read; a sticky flag reports stalled slaves.
module axil_cmd_master
    import axil_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      busy,
    output logic                      timeout,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_SET = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
    logic                      write_q, write_d;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic                      bready_q, bready_d;
    logic                      arvalid_q, arvalid_d;
    logic                      rready_q, rready_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic                      rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                rsp_resp_q, rsp_resp_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      timeout_q, timeout_d;

    logic aw_hs, w_hs, waiting;

    assign aw_hs   = awvalid_q && M_AXI_AWREADY;
    assign w_hs    = wvalid_q && M_AXI_WREADY;
    assign waiting = state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        write_d     = write_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        cnt_d       = cnt_q;
        timeout_d   = timeout_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    write_d   = cmd_write;
                    timeout_d = 1'b0;
                    if (cmd_write) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            // AW and W retire independently; the same-cycle handshakes count toward leaving.
            WR_REQ: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (M_AXI_BVALID) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = write_q;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = M_AXI_BRESP;
                    state_d     = RSP;
                end
            end
            RD_REQ: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (M_AXI_RVALID) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = write_q;
                    rsp_rdata_d = M_AXI_RDATA;
                    rsp_resp_d  = M_AXI_RRESP;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Stall counter restarts per state; the flag only raises, the FSM keeps waiting.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (waiting && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (waiting && cnt_q == CNT_SET) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            write_q     <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            write_q     <= write_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign timeout       = timeout_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: doc/axil_cmd_master.md
# axil_cmd_master

- AXI4-Lite initiator that turns a simple command/response handshake into single-beat AXI4-Lite write and read transactions.
- Sits in the same fabric as the axi2regs register slave: firmware-less control paths (sequencers, debug/UART bridges) use it to reach axi2regs-style register banks.
- One transaction is outstanding at a time.
- A cycle counter flags slaves that stall.

## Interface
Parameters:
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width; only 32 is supported
- TIMEOUT_CYCLES, 1024, wait cycles before `timeout` is flagged; must be ≥2

Ports:
- ACLK  in  1  clock; everything is rising-edge
- ARESET  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  write strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_write  out  1  echoes cmd_write of the completed command
- rsp_rdata  out  DATA_WIDTH  RDATA for reads; 0 for writes
- rsp_resp  out  2  BRESP or RRESP
- busy  out  1  high when state ≠ IDLE
- timeout  out  1  sticky stall flag
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARPROT/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY
  - Standard AXI4-Lite master side.
  - AWPROT = ARPROT = 3'b000 constant.

## Operation
States:
- IDLE: cmd_ready=1.
  - On cmd_valid, latch addr/wdata/wstrb/write and clear `timeout`.
  - Go to WR_REQ (write) or RD_REQ (read).
- WR_REQ:
  - AWVALID and WVALID are asserted together on entry.
  - Each is dropped independently on its own handshake; an aw_done/w_done flag pair tracks them.
  - AW before W, W before AW, and both in the same cycle are all legal.
  - Go to WR_RESP when both flags are set, counting handshakes in the current cycle.
- WR_RESP: BREADY=1. On BVALID, latch BRESP and go to RSP.
- RD_REQ: ARVALID=1. On ARREADY, go to RD_DATA.
- RD_DATA: RREADY=1. On RVALID, latch RDATA and RRESP and go to RSP.
- RSP: rsp_valid=1, rsp_* held stable. On rsp_ready, go to IDLE.

Other rules:
- AXI outputs are registered. No VALID is deasserted before its handshake.
- rsp_rdata is forced to 0 for writes.
- Timeout counter:
  - Cleared on every state entry; increments each cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA; saturates.
  - When it reaches TIMEOUT_CYCLES, `timeout` is set.
  - The FSM keeps waiting: a transaction is never abandoned, because that would violate AXI.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Reset values: state IDLE; cmd_ready 1; all VALID/READY outputs 0; rsp_* 0; busy 0; timeout 0; addr/data registers 0.
- ARESET mid-transaction returns to IDLE on the next edge. ARESET must be shared with the addressed slave.

## Timing
- cmd handshake at edge 0. AWVALID/WVALID or ARVALID are high from cycle 1.
- With a zero-wait slave:
  - Address/data handshake in cycle 1.
  - BREADY/RREADY in cycle 2; BVALID/RVALID sampled in cycle 2.
  - rsp_valid in cycle 3.
- rsp handshake in cycle 3 puts cmd_ready high in cycle 4. Peak rate is one transaction per 4 cycles.
- Each slave wait cycle adds exactly one cycle of latency.
- cmd_ready is combinational from state only; it has no dependence on cmd_valid.

## Structure
- Package axil_master_pkg holds:
  - the state_t enum (IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP);
  - AXI response constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
- Single module, no sub-modules. The timeout counter is inline.

## Test plan
- Zero-wait slave:
  - Stimulus: write 0x00000001 to 0x0, then read 0x0.
  - Required: rsp_valid in cycle 3 of each transaction; rsp_resp=OKAY; read returns 0x00000001; write rsp_rdata=0.
- Skewed handshakes:
  - Stimulus: AWREADY 3 cycles late with WREADY immediate, then the reverse, then both in the same cycle. Data 0xA5A5A5A5 to 0x4.
  - Required: each VALID drops right after its own handshake; BREADY rises only once both are done; read-back matches.
- Response backpressure:
  - Stimulus: hold rsp_ready low for 5 cycles.
  - Required: rsp_* stable; cmd_ready stays 0 until the cycle after the rsp handshake.
- Error propagation:
  - Stimulus: slave returns SLVERR on a write and DECERR on a read at 0xC.
  - Required: rsp_resp=2'b10, then 2'b11.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16; ARREADY withheld for 20 cycles.
  - Required: `timeout` rises exactly 16 cycles after ARVALID asserts; the transaction still completes; `timeout` clears on the next cmd acceptance.
- Reset mid-operation:
  - Stimulus: ARESET asserted during WR_RESP.
  - Required: on the next edge, BREADY=0, busy=0, cmd_ready=1; the following read still works.
